instruction_fetch_register: RTL

//   Fetch stage directly upstream of control_unit. On a fetch request it reads one 16-bit word at PC

---
 rtl/instruction_fetch_register_pkg.sv | 25 ++
 rtl/instruction_fetch_register_if.sv | 28 ++
 rtl/instruction_fetch_register_imm_extend.sv | 13 +
 rtl/instruction_fetch_register.sv | 138 +++++++++++++
 4 files changed

// File: rtl/instruction_fetch_register_pkg.sv
// Shared fetch-stage definitions: FSM state encodings, instruction field positions
// and the opcode constants that control_unit decodes.
package instruction_fetch_register_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetchState_e;

    localparam int INSTR_W  = 16;
    localparam int OPC_HI   = 15;
    localparam int OPC_LO   = 11;
    localparam int FLAG_BIT = 10;
    localparam int IMM_HI   = 9;

    localparam logic [4:0] OPC_SPUT = 5'd1;
    localparam logic [4:0] OPC_AADD = 5'd2;
    localparam logic [4:0] OPC_ASUB = 5'd3;
    localparam logic [4:0] OPC_SPEK = 5'd4;
    localparam logic [4:0] OPC_SPOP = 5'd5;
    localparam logic [4:0] OPC_APUT = 5'd10;

endpackage

// File: rtl/instruction_fetch_register_if.sv
// Fetch-stage bus: control_unit request, instruction memory handshake and decoded IR fields.
interface instruction_fetch_register_if #(
    parameter int ADDR_W = 16
);
    logic              FetchStart;
    logic [ADDR_W-1:0] PC;
    logic [15:0]       MemRData;
    logic              MemReady;
    logic              MemReq;
    logic [ADDR_W-1:0] MemAddr;
    logic [4:0]        OPCODE;
    logic              flagbit;
    logic [15:0]       ImmSE;
    logic [15:0]       ImmZE;
    logic              IRValid;
    logic              FetchBusy;
    logic              FetchErr;

    modport master (
        output FetchStart, PC, MemRData, MemReady,
        input  MemReq, MemAddr, OPCODE, flagbit, ImmSE, ImmZE, IRValid, FetchBusy, FetchErr
    );

    modport slave (
        input  FetchStart, PC, MemRData, MemReady,
        output MemReq, MemAddr, OPCODE, flagbit, ImmSE, ImmZE, IRValid, FetchBusy, FetchErr
    );
endinterface

// File: rtl/instruction_fetch_register_imm_extend.sv
// Combinational widening of the 10-bit IR immediate into sign- and zero-extended forms.
module instruction_fetch_register_imm_extend
    import instruction_fetch_register_pkg::*;
(
    input  logic [IMM_HI:0]      immField,
    output logic [INSTR_W-1:0]   immSE,
    output logic [INSTR_W-1:0]   immZE
);
    localparam int EXT_W = INSTR_W - IMM_HI - 1;

    assign immSE = {{EXT_W{immField[IMM_HI]}}, immField};
    assign immZE = {{EXT_W{1'b0}}, immField};
endmodule

// File: rtl/instruction_fetch_register.sv
// Instruction fetch stage: reads one word at PC over a ready handshake into IR, which
// stays constant until the next successful fetch, and decodes it for control_unit.
module instruction_fetch_register
    import instruction_fetch_register_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic                        CLK,
    input  logic                        Reset,
    instruction_fetch_register_if.slave fetchBus
);
    localparam logic [3:0] TIMEOUT_C = 4'(TIMEOUT);

    fetchState_e        state;
    fetchState_e        nextState;
    logic [INSTR_W-1:0] irReg;
    logic [INSTR_W-1:0] irNext;
    logic [ADDR_W-1:0]  memAddrReg;
    logic [ADDR_W-1:0]  memAddrNext;
    logic [3:0]         waitCnt;
    logic [3:0]         waitCntNext;
    logic [3:0]         waitCntInc;
    logic               memReqReg;
    logic               memReqNext;
    logic               irValidReg;
    logic               irValidNext;
    logic               busyReg;
    logic               busyNext;
    logic               errReg;
    logic               errNext;

    // waitCntInc counts the current WAIT cycle, so the TIMEOUT-th WAIT cycle is the last one
    assign waitCntInc = waitCnt + 4'd1;

    // State register
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic; a ready on the timeout cycle still completes the fetch
    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE: begin
                if (fetchBus.FetchStart) nextState = ST_REQ;
                else                     nextState = ST_IDLE;
            end
            ST_REQ: begin
                if (fetchBus.MemReady) nextState = ST_DONE;
                else                   nextState = ST_WAIT;
            end
            ST_WAIT: begin
                if (fetchBus.MemReady)            nextState = ST_DONE;
                else if (waitCntInc == TIMEOUT_C) nextState = ST_IDLE;
                else                              nextState = ST_WAIT;
            end
            ST_DONE: nextState = ST_IDLE;
            default: nextState = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, IR, fetch address and timeout counter
    always_comb begin
        memReqNext  = (nextState == ST_REQ) || (nextState == ST_WAIT);
        busyNext    = memReqNext;
        irValidNext = (nextState == ST_DONE);
        irNext      = irReg;
        memAddrNext = memAddrReg;
        waitCntNext = waitCnt;
        errNext     = errReg;
        case (state)
            ST_IDLE: begin
                if (fetchBus.FetchStart) begin
                    memAddrNext = fetchBus.PC;
                    waitCntNext = 4'd0;
                    errNext     = 1'b0;
                end else begin
                    memAddrNext = memAddrReg;
                end
            end
            ST_REQ: begin
                if (fetchBus.MemReady) irNext = fetchBus.MemRData;
                else                   irNext = irReg;
            end
            ST_WAIT: begin
                if (fetchBus.MemReady) begin
                    irNext = fetchBus.MemRData;
                end else if (waitCntInc == TIMEOUT_C) begin
                    errNext = 1'b1;
                end else begin
                    waitCntNext = waitCntInc;
                end
            end
            ST_DONE: irNext = irReg;
            default: irNext = irReg;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            irReg      <= {INSTR_W{1'b0}};
            memAddrReg <= {ADDR_W{1'b0}};
            waitCnt    <= 4'd0;
            memReqReg  <= 1'b0;
            irValidReg <= 1'b0;
            busyReg    <= 1'b0;
            errReg     <= 1'b0;
        end else begin
            irReg      <= irNext;
            memAddrReg <= memAddrNext;
            waitCnt    <= waitCntNext;
            memReqReg  <= memReqNext;
            irValidReg <= irValidNext;
            busyReg    <= busyNext;
            errReg     <= errNext;
        end
    end

    instruction_fetch_register_imm_extend immExt (
        .immField (irReg[IMM_HI:0]),
        .immSE    (fetchBus.ImmSE),
        .immZE    (fetchBus.ImmZE)
    );

    assign fetchBus.MemReq    = memReqReg;
    assign fetchBus.MemAddr   = memAddrReg;
    assign fetchBus.OPCODE    = irReg[OPC_HI:OPC_LO];
    assign fetchBus.flagbit   = irReg[FLAG_BIT];
    assign fetchBus.IRValid   = irValidReg;
    assign fetchBus.FetchBusy = busyReg;
    assign fetchBus.FetchErr  = errReg;
endmodule
